fp_add_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with a valid/ready stream interface. Generalises the team's single-precision combinational adder:
- Width is set by parameters.
- Operand alignment uses the hidden bit, guard/round/sticky bits and round-to-nearest-even.
- Zero, Inf and NaN are handled.
- Three-stage pipeline with backpressure.

Sits in the arithmetic datapath between operand FIFOs and the result writeback.

---
 rtl/fp_add_pkg.sv | 50 +++++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_add_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
// Stage records are sized for binary64; narrower formats occupy the low bits of each field.
package fp_add_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam int EXP_MAX  = 11;
    localparam int MAN_MAX  = 52;
    localparam int WORD_MAX = EXP_MAX + MAN_MAX + 1;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // S1 -> S2: operands already swapped so man_a is the larger magnitude
    typedef struct packed {
        logic               sign;
        logic               eff_sub;
        logic [EXP_MAX-1:0] exp;
        logic [MAN_MAX+3:0] man_a;
        logic [MAN_MAX+3:0] man_b;
        logic               nan;
        logic               inf;
        logic               zz;
        logic               zz_sign;
    } s1_rec_t;

    typedef struct packed {
        logic               sign;
        logic [EXP_MAX-1:0] exp;
        logic [MAN_MAX+4:0] sum;
        logic               nan;
        logic               inf;
        logic               zz;
        logic               zz_sign;
    } s2_rec_t;

    // Inf (nan=0) or canonical qNaN (nan=1, pass sign=0) for a given format
    function automatic logic [WORD_MAX-1:0] special_word(input int exp_w, input int man_w,
                                                         input logic sign, input logic nan);
        logic [WORD_MAX-1:0] w;
        w = ((WORD_MAX'(1) << exp_w) - WORD_MAX'(1)) << man_w;
        w = w | (WORD_MAX'(sign) << (exp_w + man_w));
        w = w | (WORD_MAX'(nan) << (man_w - 1));
        return w;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 25,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754 add/subtract (unpack/align, add, normalise/round) with a global stall.
// Define FP_ADD_PIPE_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FP_ADD_PIPE_FLAGS_EN
    output logic [3:0]   flags,
`endif
    output logic [W-1:0] result
);

    localparam int STAGES = 3;
    localparam int MW     = MAN_W + 4;
    localparam int LZW    = $clog2(MAN_W + 3);
    localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MW);

    logic [STAGES:1] vld_pipe_q;
    logic            advance;
    s1_rec_t         s1_d, s1_q;
    s2_rec_t         s2_d, s2_q;
    logic [W-1:0]    res_d, res_q;

    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign out_valid = vld_pipe_q[STAGES];
    assign result    = res_q;

    // ---------------- S1: unpack, swap, align ----------------
    logic             sx, sy, zx, zy, ix, iy, nx, ny, swap;
    logic [EXP_W-1:0] ex, ey, ea, eb, d;
    logic [MAN_W-1:0] fx, fy;
    logic [MAN_W:0]   ma, mb;
    logic [MW-1:0]    ext, shr, lost, aligned;

    always_comb begin
        sx = x[W-1];
        sy = y[W-1] ^ sub;
        ex = x[W-2:MAN_W];
        ey = y[W-2:MAN_W];
        zx = (ex == '0);
        zy = (ey == '0);
        fx = zx ? '0 : x[MAN_W-1:0];
        fy = zy ? '0 : y[MAN_W-1:0];
        ix = (&ex) && (fx == '0);
        iy = (&ey) && (fy == '0);
        nx = (&ex) && (fx != '0);
        ny = (&ey) && (fy != '0);
        swap = {ey, fy} > {ex, fx};
        ea = swap ? ey : ex;
        eb = swap ? ex : ey;
        ma = swap ? {~zy, fy} : {~zx, fx};
        mb = swap ? {~zx, fx} : {~zy, fy};
        d  = ea - eb;

        ext  = {mb, 3'b000};
        shr  = ext >> d;
        lost = ext & ~({MW{1'b1}} << d);
        if (d >= SH_MAX) aligned = {{(MW-1){1'b0}}, |mb};
        else             aligned = {shr[MW-1:1], shr[0] | (|lost)};

        s1_d         = '0;
        s1_d.sign    = swap ? sy : sx;
        s1_d.eff_sub = sx ^ sy;
        s1_d.exp     = EXP_MAX'(ea);
        s1_d.man_a   = (MAN_MAX+4)'({ma, 3'b000});
        s1_d.man_b   = (MAN_MAX+4)'(aligned);
        s1_d.nan     = nx | ny | (ix & iy & (sx ^ sy));
        s1_d.inf     = ix | iy;
        s1_d.zz      = zx & zy;
        s1_d.zz_sign = sx & sy;
    end

    // ---------------- S2: magnitude add/subtract ----------------
    logic [MW:0] sum2;

    always_comb begin
        if (s1_q.eff_sub) sum2 = {1'b0, s1_q.man_a[MW-1:0]} - {1'b0, s1_q.man_b[MW-1:0]};
        else              sum2 = {1'b0, s1_q.man_a[MW-1:0]} + {1'b0, s1_q.man_b[MW-1:0]};

        s2_d         = '0;
        s2_d.sign    = s1_q.sign;
        s2_d.exp     = s1_q.exp;
        s2_d.sum     = (MAN_MAX+5)'(sum2);
        s2_d.nan     = s1_q.nan;
        s2_d.inf     = s1_q.inf;
        s2_d.zz      = s1_q.zz;
        s2_d.zz_sign = s1_q.zz_sign;
    end

    // ---------------- S3: normalise, round, specials ----------------
    logic [MW:0]       sum3;
    logic [EXP_W-1:0]  ea3;
    logic [LZW-1:0]    lz;
    logic [MW-1:0]     m;
    logic [EXP_W:0]    exp_n, exp_r;
    logic [MAN_W+1:0]  mant_r;
    logic              flush, inc, ovf, is_ovf, is_unf;
    logic [WORD_MAX-1:0] qnan_w, inf_w;

    assign sum3   = s2_q.sum[MW:0];
    assign ea3    = s2_q.exp[EXP_W-1:0];
    assign qnan_w = special_word(EXP_W, MAN_W, 1'b0, 1'b1);
    assign inf_w  = special_word(EXP_W, MAN_W, s2_q.sign, 1'b0);

    // window stops at G: a multi-bit left shift only follows a 0/1 exponent gap, where R and S are clear
    fp_lzc #(.WIDTH(MAN_W + 2)) u_lzc (
        .data_i  (sum3[MW-1:2]),
        .count_o (lz)
    );

    always_comb begin
        m     = '0;
        exp_n = '0;
        flush = 1'b0;
        if (sum3[MW]) begin
            m     = {sum3[MW:2], sum3[1] | sum3[0]};
            exp_n = {1'b0, ea3} + (EXP_W+1)'(1);
        end else begin
            m     = sum3[MW-1:0] << lz;
            exp_n = {1'b0, ea3} - (EXP_W+1)'(lz);
            flush = ({1'b0, ea3} <= (EXP_W+1)'(lz));
        end
        inc    = m[2] & (m[1] | m[0] | m[3]);
        mant_r = {1'b0, m[MW-1:3]} + (MAN_W+2)'(inc);
        exp_r  = exp_n + (EXP_W+1)'(mant_r[MAN_W+1]);
        ovf    = (exp_r >= {1'b0, {EXP_W{1'b1}}});

        res_d  = {s2_q.sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        is_ovf = 1'b0;
        is_unf = 1'b0;
        if (s2_q.nan)       res_d = qnan_w[W-1:0];
        else if (s2_q.inf)  res_d = inf_w[W-1:0];
        else if (s2_q.zz)   res_d = {s2_q.zz_sign, {(W-1){1'b0}}};
        else if (sum3 == '0) res_d = '0;
        else if (flush) begin
            res_d  = {s2_q.sign, {(W-1){1'b0}}};
            is_unf = 1'b1;
        end else if (ovf) begin
            res_d  = inf_w[W-1:0];
            is_ovf = 1'b1;
        end
    end

`ifdef FP_ADD_PIPE_FLAGS_EN
    logic [3:0] flags_d, flags_q;
    assign flags = flags_q;

    always_comb begin
        flags_d                = '0;
        flags_d[FLG_INVALID]   = s2_q.nan;
        flags_d[FLG_OVERFLOW]  = is_ovf;
        flags_d[FLG_UNDERFLOW] = is_unf;
        flags_d[FLG_INEXACT]   = is_ovf | is_unf |
                                 (~s2_q.nan & ~s2_q.inf & ~s2_q.zz & (|m[2:0]));
    end
`endif

    // record bits above the configured format width, and the rounded hidden bit, are idle
    logic unused_bits;
    assign unused_bits = ^{s1_q, s2_q, qnan_w, inf_w, mant_r[MAN_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            res_q      <= '0;
`ifdef FP_ADD_PIPE_FLAGS_EN
            flags_q    <= '0;
`endif
        end else if (advance) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            res_q      <= res_d;
`ifdef FP_ADD_PIPE_FLAGS_EN
            flags_q    <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe (binary32): latency, rounding, specials, backpressure, mid-flight reset.
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] x, y, result;
`ifdef FP_ADD_PIPE_FLAGS_EN
    logic [3:0]  flags;
`endif
    logic [3:0]  flg_unused;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FP_ADD_PIPE_FLAGS_EN
        .flags     (flags),
`endif
        .result    (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one operation, then check valid timing and the value on the third edge
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_r, input logic [3:0] flg_exp);
        in_valid = 1'b1; x = a; y = b; sub = s; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_v1"}, out_valid, 0);
        step();
        chk({tag, "_v2"}, out_valid, 0);
        step();
        chk({tag, "_v3"}, out_valid, 1);
        chk({tag, "_res"}, result, exp_r);
`ifdef FP_ADD_PIPE_FLAGS_EN
        chk({tag, "_flags"}, flags, flg_exp);
`else
        flg_unused = flg_exp;
`endif
        step();
    endtask

    logic [31:0] bp_x [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
                              32'hC0000000, 32'h41200000, 32'h3F000000, 32'h42C80000};
    logic [31:0] bp_y [8] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000,
                              32'h3F800000, 32'h40A00000, 32'h3E800000, 32'h42480000};
    logic        bp_s [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] bp_e [8] = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h40400000,
                              32'hBF800000, 32'h41700000, 32'h3F400000, 32'h42480000};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  ni, no, cyc;
        logic was_stalled;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        x = '0; y = '0; flg_unused = '0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        run_op("add_1p1",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        run_op("sub_3m1",    32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        run_op("cancel",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        run_op("tie_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        run_op("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_op("nan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("negz_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_op("x_plus_0",   32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 4'b0000);
        run_op("inf_plus_1", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
        run_op("renorm",     32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000);
        run_op("underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        run_op("sticky",     32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op("zero_m_one", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000);

        // backpressure: out_ready low for 2 cycles, high for 2
        ni = 0; no = 0; cyc = 0; was_stalled = 1'b0;
        while (no < 8 && cyc < 200) begin
            out_ready = ((cyc / 2) % 2) == 1;
            in_valid  = (ni < 8);
            if (ni < 8) begin
                x = bp_x[ni]; y = bp_y[ni]; sub = bp_s[ni];
            end
            #1;
            if (was_stalled) chk("bp_hold_valid", out_valid, 1);
            if (out_valid && !out_ready) chk("bp_in_ready_stall", in_ready, 0);
            else                         chk("bp_in_ready_go", in_ready, 1);
            if (out_valid) chk($sformatf("bp_res%0d", no), result, bp_e[no]);
            was_stalled = out_valid && !out_ready;
            if (out_valid && out_ready) no++;
            if (in_valid && in_ready) ni++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_count", no, 8);

        // reset with three operations in flight
        out_ready = 1'b1;
        in_valid = 1'b1; x = 32'h3F800000; y = 32'h3F800000; sub = 1'b0;
        step();
        x = 32'h40000000; y = 32'h40000000;
        step();
        x = 32'h40400000; y = 32'h3F800000;
        step();
        in_valid = 1'b0;
        chk("mid_valid_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mid_no_stale%0d", k), out_valid, 0);
        end
        run_op("after_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
